// File: rtl/sr_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and memory.
interface sr_fetch_queue_if;
    logic        imReq;
    logic [31:0] imAddr;
    logic        imAck;
    logic [31:0] imData;

    modport master (
        output imReq,
        output imAddr,
        input  imAck,
        input  imData
    );

    modport slave (
        input  imReq,
        input  imAddr,
        output imAck,
        output imData
    );
endinterface

// File: rtl/sr_fetch_queue.sv
// Fetch queue: one outstanding imem request, DEPTH-entry FIFO toward decode.
// Optional SR_FETCH_QUEUE_BYPASS_EN forwards a response straight to decode.
module sr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_fetch_queue_if.master im,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o,
    input  logic        redirect_i,
    input  logic [31:0] redirectPc_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [31:0]   reqAddr_q, reqAddr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instrMem_q [DEPTH];
    logic [31:0]   pcMem_q    [DEPTH];

    logic hasRoom, ackKeep, bypass, push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (!redirect_i && hasRoom) state_d = S_REQ;
            S_REQ: begin
                if (im.imAck)        state_d = S_IDLE;
                else if (redirect_i) state_d = S_DISCARD;
            end
            S_DISCARD: if (im.imAck) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        im.imReq  = (state_q != S_IDLE);
        im.imAddr = reqAddr_q;
        valid_o   = (cnt_q != '0) || bypass;
        instr_o   = bypass ? im.imData : instrMem_q[rptr_q];
        pc_o      = bypass ? reqAddr_q : pcMem_q[rptr_q];
        pcPlus4_o = pc_o + 32'd4;
    end

    // A response is kept only in REQ and only if no redirect lands with it.
    always_comb begin
        hasRoom = (cnt_q < CW'(DEPTH));
        ackKeep = (state_q == S_REQ) && im.imAck && !redirect_i;
`ifdef SR_FETCH_QUEUE_BYPASS_EN
        bypass  = ackKeep && (cnt_q == '0);
`else
        bypass  = 1'b0;
`endif
        pop     = (cnt_q != '0) && ready_i && !redirect_i;
        push    = ackKeep && !(bypass && ready_i);
    end

    always_comb begin
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        wptr_d    = wptr_q + PW'(push);
        rptr_d    = rptr_q + PW'(pop);
        fetchPc_d = fetchPc_q;
        reqAddr_d = reqAddr_q;
        if (ackKeep) fetchPc_d = fetchPc_q + 32'd4;
        if (redirect_i) begin
            cnt_d     = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            fetchPc_d = redirectPc_i & 32'hFFFF_FFFC;
        end
        if (state_q == S_IDLE && state_d == S_REQ) reqAddr_d = fetchPc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q <= RESET_PC & 32'hFFFF_FFFC;
            reqAddr_q <= RESET_PC & 32'hFFFF_FFFC;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            reqAddr_q <= reqAddr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instrMem_q[i] <= '0;
                pcMem_q[i]    <= '0;
            end
        end else if (push) begin
            instrMem_q[wptr_q] <= im.imData;
            pcMem_q[wptr_q]    <= reqAddr_q;
        end
    end
endmodule

// File: tb/tb_sr_fetch_queue.sv
// Randomized bench for sr_fetch_queue against a program-order queue model.
module tb_sr_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_o, ready_i;
    logic [31:0] instr_o, pc_o, pcPlus4_o;
    logic        redirect_i;
    logic [31:0] redirectPc_i;

    sr_fetch_queue_if im();

    sr_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im          (im),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .pcPlus4_o   (pcPlus4_o),
        .redirect_i  (redirect_i),
        .redirectPc_i(redirectPc_i)
    );

    always #5 clk = ~clk;

    int nRun  = 0;
    int nFail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nRun++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Words delivered to decode, in program order.
    ent_t        mq[$];
    bit          out, stale, junkAck;
    logic [31:0] outAddr, mPc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic step(input bit rdy, input int redirPct, input int ackPct);
        bit          ack, rd, byp, keep, popQ;
        logic [31:0] tgt;
        ent_t        h;
        int          sz;
        ack = junkAck || (im.imReq && ($urandom_range(0, 99) < ackPct));
        junkAck = 1'b0;
        rd = ($urandom_range(0, 99) < redirPct);
        case ($urandom_range(0, 3))
            0:       tgt = 32'h0000_0103;
            1:       tgt = 32'hFFFF_FFFC;
            2:       tgt = 32'hFFFF_FFF9;
            default: tgt = $urandom;
        endcase
        ready_i      = rdy;
        redirect_i   = rd;
        redirectPc_i = tgt;
        im.imAck     = ack;
        im.imData    = (ack && im.imReq) ? memWord(im.imAddr) : $urandom;
        #1;
        sz = mq.size();
        chk("imReq", 32'(im.imReq), 32'(out));
        if (out) chk("imAddr", im.imAddr, outAddr);
        byp = 1'b0;
`ifdef SR_FETCH_QUEUE_BYPASS_EN
        byp = (sz == 0) && out && !stale && ack && !rd;
`endif
        h = '{32'h0, 32'h0};
        if (byp) h = '{outAddr, memWord(outAddr)};
        else if (sz != 0) h = mq[0];
        chk("valid_o", 32'(valid_o), 32'((sz != 0) || byp));
        if ((sz != 0) || byp) begin
            chk("pc_o", pc_o, h.pc);
            chk("instr_o", instr_o, h.ins);
            chk("pcPlus4_o", pcPlus4_o, h.pc + 32'd4);
        end
        popQ = (sz != 0) && rdy && !rd;
        keep = out && !stale && ack && !rd;
        if (out) begin
            if (ack) out = 1'b0;
            else if (rd) stale = 1'b1;
        end else if (!rd && sz < DEPTH) begin
            out     = 1'b1;
            stale   = 1'b0;
            outAddr = mPc;
        end
        if (rd) begin
            mq.delete();
            mPc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (popQ) void'(mq.pop_front());
            if (keep) begin
                mPc = outAddr + 32'd4;
                if (!(byp && rdy)) mq.push_back('{outAddr, memWord(outAddr)});
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        #2;
        rst_n    = 1'b0;
        im.imAck = 1'b0;
        #1;
        chk("rst_imReq", 32'(im.imReq), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_imAddr", im.imAddr, RPC);
        mq.delete();
        out   = 1'b0;
        stale = 1'b0;
        mPc   = RPC;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        junkAck = 1'b1;
    endtask

    initial begin
        ready_i      = 1'b0;
        redirect_i   = 1'b0;
        redirectPc_i = '0;
        im.imAck     = 1'b0;
        im.imData    = '0;
        out          = 1'b0;
        stale        = 1'b0;
        outAddr      = '0;
        mPc          = RPC;
        junkAck      = 1'b0;
        #1;
        chk("init_imReq", 32'(im.imReq), 32'h0);
        chk("init_valid", 32'(valid_o), 32'h0);
        chk("init_imAddr", im.imAddr, RPC);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        junkAck = 1'b1;
        repeat (20) step(1'b1, 0, 100);
        repeat (30) step(1'b0, 0, 100);
        step(1'b1, 0, 100);
        repeat (10) step(1'b0, 0, 100);
        repeat (40) step(1'b1, 0, 100);
        repeat (300) step(1'($urandom_range(0, 1)), 10, 40);
        step(1'b1, 0, 0);
        doReset();
        repeat (200) step(1'($urandom_range(0, 1)), 15, 60);
        doReset();
        repeat (150) step(1'b1, 5, 100);
        repeat (150) step(1'($urandom_range(0, 3) != 0), 20, 30);
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
